comp_trip_finder: RTL and testbench
===================================

Name: comp_trip_finder

Overview:
- Digital consumer of the comparator test path: the counterpart of the DAC/comparator macro.
- Drives a DAC code sequence and samples the differential comparator decision (comp_p/comp_m) at each code.
- Finds the lowest code at which the comparator decides "1" by majority. This is the trip point used for offset characterization of the NAND, AO22 and MX21 comparator variants.
- Sits beside the macro in the tile; its code output feeds the DAC counter inputs and its comparator inputs come from the selected comparator pair.

Parameters:
- CODE_W, 8, width of the DAC code swept (0 .. 2^CODE_W-1)
- SETTLE, 4, cycles waited after each code change before sampling; minimum 2, which covers the input synchronizer
- INV_W, 16, width of the saturating invalid-decision counter

Ports:
- clk  input  1  system clock, also the comparator strobe clock
- rst  input  1  synchronous reset, active-high
- start  input  1  single-cycle request to begin a sweep; ignored while busy
- win_len  input  8  samples per code; 0 means 256; captured on accepted start
- comp_p  input  1  comparator positive output, asynchronous to the sampling point
- comp_m  input  1  comparator negative output
- code_out  output  CODE_W  current DAC code
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when a sweep finishes
- trip_found  output  1  a trip code was found in the last sweep
- trip_code  output  CODE_W  first code with a majority of ones; all-ones if not found
- ones_cnt  output  9  ones counted in the last completed window
- invalid_cnt  output  INV_W  samples with comp_p==comp_m, saturating, for the last sweep

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. While rst is high at a clk edge, all outputs and state go to 0 and the FSM goes to IDLE. This applies mid-sweep too: no done pulse is issued, and results are cleared, not held.
- Input conditioning: comp_p/comp_m each pass through a 2-flop synchronizer. Only the synchronized values are used below.
- Sample classification:
  - one = (p==1 && m==0)
  - zero = (p==0 && m==1)
  - invalid = (p==m)
  - An invalid sample consumes a window slot and increments invalid_cnt, which saturates at all-ones.
  - An invalid sample does not increment the window ones count.
- FSM states: IDLE, SETTLE, SAMPLE, EVAL, FIN.
  - IDLE: busy=0. When start=1:
    - capture win_len into n (9-bit; 0 becomes 256)
    - code_out<=0; invalid_cnt<=0; trip_found<=0; trip_code<=0
    - clear the settle counter
    - go to SETTLE
  - SETTLE: count SETTLE cycles, then clear the sample and ones counters and go to SAMPLE.
  - SAMPLE: one classified sample per cycle for exactly n cycles, then go to EVAL.
  - EVAL (one cycle):
    - ones_cnt <= window ones.
    - Majority if 2*ones > n (strict; a tie is not a trip). Use ≥10-bit compare, no overflow.
    - Majority: trip_code<=code_out, trip_found<=1, go to FIN.
    - Else if code_out == all-ones: trip_code<=all-ones, trip_found<=0, go to FIN.
    - Else: code_out<=code_out+1 (no wrap is possible), go to SETTLE.
  - FIN: done=1 for this cycle only; busy=0 from the next cycle; go to IDLE.
- Holding and restart:
  - code_out holds its last value in IDLE.
  - Results hold until the next accepted start or reset.
  - start is ignored in every state except IDLE.
  - A start in the same cycle FIN returns to IDLE is not accepted; it is accepted from the following cycle.
- Latency per code: SETTLE + n + 1 cycles. A full sweep with no trip takes 2^CODE_W*(SETTLE+n+1) + 2 cycles from the start edge to the done pulse.

Test Plan:
- Reset idle: hold rst 2 cycles -> all outputs 0, busy=0. start=1 with rst=1 -> no sweep.
- Clean trip: win_len=8; comparator model outputs one (p=1,m=0) when code_out>=37, else zero -> done after 38*(4+8+1)+2 cycles, trip_found=1, trip_code=37, ones_cnt=8, invalid_cnt=0.
- Tie rule: win_len=4; at code 5 exactly 2 ones, at code 6 exactly 3 ones -> trip_code=6, ones_cnt=3. Code 5 must not trip.
- No trip and invalids: comp_p=comp_m=1 constantly, win_len=0 (256 samples) -> trip_found=0, trip_code=255, invalid_cnt=65535 (saturated, since 65536 samples), ones_cnt=0.
- Start while busy: pulse start again mid-sweep of the clean-trip case -> ignored, result identical, exactly one done pulse.
- Reset mid-sweep: assert rst during SAMPLE at code 10 -> next cycle code_out=0, busy=0, no done. Then a fresh start gives the clean-trip result.

Source files
------------

// File: rtl/comp_trip_finder.sv
`timescale 1ns/1ps
// comp_trip_finder: sweeps the DAC code upward from 0, takes a window of
// comparator decisions at each code, and reports the first code whose window
// holds a strict majority of ones. Used for comparator offset characterization.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; results and code_out hold
// SETTLE | DAC/comparator settling after a code change
// SAMPLE | one classified comparator sample per cycle, n cycles
// EVAL   | majority decision for the current code
// FIN    | one-cycle done pulse, then back to IDLE
module comp_trip_finder #(
  parameter int CODE_W = 8,
  parameter int SETTLE = 4,
  parameter int INV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        win_len,
  input  logic              comp_p,
  input  logic              comp_m,
  output logic [CODE_W-1:0] code_out,
  output logic              busy,
  output logic              done,
  output logic              trip_found,
  output logic [CODE_W-1:0] trip_code,
  output logic [8:0]        ones_cnt,
  output logic [INV_W-1:0]  invalid_cnt
);

  localparam int SET_W = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic             p_s1, p_s2, m_s1, m_s2;
  logic [8:0]       n_q;
  logic [SET_W-1:0] settle_cnt;
  logic [8:0]       samp_cnt;
  logic [8:0]       win_ones;
  logic             samp_one;
  logic             samp_inv;
  logic             majority;

  // two-flop synchronizers on the comparator outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      p_s1 <= 1'b0;
      p_s2 <= 1'b0;
      m_s1 <= 1'b0;
      m_s2 <= 1'b0;
    end else begin
      p_s1 <= comp_p;
      p_s2 <= p_s1;
      m_s1 <= comp_m;
      m_s2 <= m_s1;
    end
  end

  assign samp_one = p_s2 & ~m_s2;
  assign samp_inv = ~(p_s2 ^ m_s2);
  // 10-bit compare so 2*256 cannot overflow; a tie does not count as a trip
  assign majority = ({win_ones, 1'b0} > {1'b0, n_q});

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state decode and status outputs
  always_comb begin
    state_d = state_q;
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_FIN);
    case (state_q)
      S_IDLE:   if (start) state_d = S_SETTLE;
      S_SETTLE: if (settle_cnt == '0) state_d = S_SAMPLE;
      S_SAMPLE: if (samp_cnt == '0) state_d = S_EVAL;
      S_EVAL:   begin
        if (majority || (code_out == '1)) state_d = S_FIN;
        else                              state_d = S_SETTLE;
      end
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // sweep datapath: timers, window accumulation and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q         <= '0;
      settle_cnt  <= '0;
      samp_cnt    <= '0;
      win_ones    <= '0;
      code_out    <= '0;
      trip_found  <= 1'b0;
      trip_code   <= '0;
      ones_cnt    <= '0;
      invalid_cnt <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_q         <= (win_len == 8'd0) ? 9'd256 : {1'b0, win_len};
            code_out    <= '0;
            invalid_cnt <= '0;
            trip_found  <= 1'b0;
            trip_code   <= '0;
            settle_cnt  <= SETTLE_LOAD;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            samp_cnt <= n_q - 9'd1;
            win_ones <= '0;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_SAMPLE: begin
          if (samp_one) win_ones <= win_ones + 9'd1;
          if (samp_inv && (invalid_cnt != '1)) invalid_cnt <= invalid_cnt + 1'b1;
          if (samp_cnt != '0) samp_cnt <= samp_cnt - 9'd1;
        end
        S_EVAL: begin
          ones_cnt <= win_ones;
          if (majority) begin
            trip_code  <= code_out;
            trip_found <= 1'b1;
          end else if (code_out == '1) begin
            trip_code  <= '1;
            trip_found <= 1'b0;
          end else begin
            code_out   <= code_out + 1'b1;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_trip_finder.sv
`timescale 1ns/1ps
// Bench for comp_trip_finder. The comparator stimulus for a whole sweep is laid
// out in advance (one entry per cycle counted from the start cycle); a
// reference model walks the same table window by window to predict the sweep
// result, and every cycle of the sweep is checked against that prediction.
module tb_comp_trip_finder;

  localparam int CODE_W = 8;
  localparam int SETTLE = 4;
  localparam int INV_W  = 16;
  localparam int NCODES = 1 << CODE_W;
  localparam int INV_MAX = (1 << INV_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        win_len;
  logic              comp_p;
  logic              comp_m;
  logic [CODE_W-1:0] code_out;
  logic              busy;
  logic              done;
  logic              trip_found;
  logic [CODE_W-1:0] trip_code;
  logic [8:0]        ones_cnt;
  logic [INV_W-1:0]  invalid_cnt;

  int vectors = 0;
  int miscompares = 0;

  // stim[t] = {comp_p, comp_m} driven during cycle t of a sweep (t=0: start cycle)
  logic [1:0] stim [];

  int  m_k, m_ones, m_inv;
  bit  m_found;
  int  done_pulses;
  int  done_t;

  always #5 clk = ~clk;

  comp_trip_finder #(.CODE_W(CODE_W), .SETTLE(SETTLE), .INV_W(INV_W)) dut (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len),
    .comp_p(comp_p), .comp_m(comp_m), .code_out(code_out), .busy(busy),
    .done(done), .trip_found(trip_found), .trip_code(trip_code),
    .ones_cnt(ones_cnt), .invalid_cnt(invalid_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slot i of the window for code k is taken during cycle k*L+SETTLE+1+i and,
  // through the two-flop synchronizer, reflects the input of two cycles earlier.
  function automatic int slot_idx(input int nn, input int k, input int i);
    return k * (SETTLE + nn + 1) + SETTLE - 1 + i;
  endfunction

  task automatic fill_noise();
    foreach (stim[j]) stim[j] = 2'($urandom_range(0, 3));
  endtask

  task automatic run_model(input int nn);
    int ones;
    logic [1:0] s;
    m_inv = 0;
    m_found = 0;
    m_k = 0;
    m_ones = 0;
    for (int k = 0; k < NCODES; k++) begin
      ones = 0;
      for (int i = 0; i < nn; i++) begin
        s = stim[slot_idx(nn, k, i)];
        if (s[1] == s[0]) begin
          if (m_inv < INV_MAX) m_inv++;
        end else if (s == 2'b10) begin
          ones++;
        end
      end
      m_k = k;
      m_ones = ones;
      if (2 * ones > nn) begin
        m_found = 1;
        break;
      end
    end
  endtask

  // rst_at > 0 asserts rst during that cycle; start_again_at > 0 pulses start.
  task automatic run_sweep(input int nn, input int start_again_at, input int rst_at);
    int L, fin_t, last_t;
    L = SETTLE + nn + 1;
    run_model(nn);
    fin_t = (m_k + 1) * L + 1;
    last_t = (rst_at > 0) ? rst_at + 4 : fin_t + 2;
    done_pulses = 0;
    done_t = -1;
    win_len = 8'(nn);
    start = 1'b1;
    {comp_p, comp_m} = stim[0];
    @(negedge clk);
    chk("busy_start_cycle", busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int t = 1; t <= last_t; t++) begin
      {comp_p, comp_m} = stim[t];
      start = (t == start_again_at);
      rst = (t == rst_at);
      @(negedge clk);
      if (done === 1'b1) begin
        done_pulses++;
        if (done_t < 0) done_t = t;
      end
      if (rst_at > 0 && t > rst_at) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_code", code_out, 0);
        chk("rst_found", trip_found, 0);
        chk("rst_trip", trip_code, 0);
        chk("rst_ones", ones_cnt, 0);
        chk("rst_inv", invalid_cnt, 0);
      end else if (t < fin_t) begin
        chk("sweep_busy", busy, 1);
        chk("sweep_done", done, 0);
        chk("sweep_code", code_out, (t - 1) / L);
      end else if (t == fin_t) begin
        chk("fin_busy", busy, 1);
        chk("fin_done", done, 1);
        chk("fin_code", code_out, m_k);
        chk("fin_found", trip_found, m_found);
        chk("fin_trip", trip_code, m_found ? m_k : NCODES - 1);
        chk("fin_ones", ones_cnt, m_ones);
        chk("fin_inv", invalid_cnt, m_inv);
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_code", code_out, m_k);
        chk("idle_trip", trip_code, m_found ? m_k : NCODES - 1);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    start = 1'b0;
    chk("done_pulses", done_pulses, (rst_at > 0) ? 0 : 1);
  endtask

  task automatic build_clean(input int nn, input int thr);
    fill_noise();
    for (int k = 0; k < NCODES; k++)
      for (int i = 0; i < nn; i++)
        stim[slot_idx(nn, k, i)] = (k >= thr) ? 2'b10 : 2'b01;
  endtask

  initial begin
    int nn, thr, r;
    stim = new[NCODES * (SETTLE + 257) + 8];
    rst = 1'b1;
    start = 1'b0;
    win_len = 8'd0;
    comp_p = 1'b0;
    comp_m = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_code", code_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_found", trip_found, 0);
    chk("reset_trip", trip_code, 0);
    chk("reset_ones", ones_cnt, 0);
    chk("reset_inv", invalid_cnt, 0);
    // start while in reset must not launch a sweep
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("start_in_reset_busy", busy, 0);
      chk("start_in_reset_code", code_out, 0);
    end
    @(posedge clk);
    #1;

    // clean trip at 37 with 8-sample windows
    build_clean(8, 37);
    run_sweep(8, 0, 0);
    chk("clean_found", trip_found, 1);
    chk("clean_trip", trip_code, 37);
    chk("clean_ones", ones_cnt, 8);
    chk("clean_inv", invalid_cnt, 0);
    chk("clean_cycles", done_t + 1, 38 * (4 + 8 + 1) + 2);

    // start pulse mid-sweep is ignored
    run_sweep(8, 200, 0);
    chk("busy_start_trip", trip_code, 37);
    chk("busy_start_ones", ones_cnt, 8);

    // reset during SAMPLE at code 10, then a fresh sweep
    run_sweep(8, 0, 10 * 13 + 4 + 1 + 3);
    run_sweep(8, 0, 0);
    chk("after_rst_trip", trip_code, 37);
    chk("after_rst_found", trip_found, 1);

    // tie rule: code 5 has 2/4 ones (one invalid), code 6 has 3/4
    fill_noise();
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 4; i++) stim[slot_idx(4, k, i)] = 2'b01;
    stim[slot_idx(4, 5, 0)] = 2'b10;
    stim[slot_idx(4, 5, 1)] = 2'b10;
    stim[slot_idx(4, 5, 2)] = 2'b01;
    stim[slot_idx(4, 5, 3)] = 2'b11;
    stim[slot_idx(4, 6, 0)] = 2'b10;
    stim[slot_idx(4, 6, 1)] = 2'b01;
    stim[slot_idx(4, 6, 2)] = 2'b10;
    stim[slot_idx(4, 6, 3)] = 2'b10;
    run_sweep(4, 0, 0);
    chk("tie_trip", trip_code, 6);
    chk("tie_ones", ones_cnt, 3);
    chk("tie_inv", invalid_cnt, 1);

    // randomized sweeps with noisy windows
    for (int it = 0; it < 5; it++) begin
      nn = $urandom_range(1, 12);
      thr = $urandom_range(0, 30);
      fill_noise();
      for (int k = 0; k < NCODES; k++)
        for (int i = 0; i < nn; i++) begin
          r = $urandom_range(0, 99);
          if (r < 10) stim[slot_idx(nn, k, i)] = (r < 5) ? 2'b11 : 2'b00;
          else if ($urandom_range(0, 99) < ((k >= thr) ? 75 : 25))
            stim[slot_idx(nn, k, i)] = 2'b10;
          else stim[slot_idx(nn, k, i)] = 2'b01;
        end
      run_sweep(nn, 0, 0);
    end

    // random sweep that never trips: windows are all zeros or invalids
    fill_noise();
    for (int k = 0; k < NCODES; k++)
      for (int i = 0; i < 3; i++)
        stim[slot_idx(3, k, i)] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b00;
    run_sweep(3, 0, 0);
    chk("rand_notrip_found", trip_found, 0);
    chk("rand_notrip_trip", trip_code, 255);

    // full no-trip sweep with 256-sample windows, all invalid
    foreach (stim[j]) stim[j] = 2'b11;
    run_sweep(256, 0, 0);
    chk("notrip_found", trip_found, 0);
    chk("notrip_trip", trip_code, 255);
    chk("notrip_inv", invalid_cnt, 65535);
    chk("notrip_ones", ones_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
